ibex_rvfi_trace_buf: RTL

Parametrised retirement-trace capture buffer that sits beside `ibex_core` on the RVFI bus. It is the next generation of the core-plus-tracer pairing: instead of printing every retirement, it filters RVFI records by a run-time mode and stores them in a circular buffer of configurable depth. Records are drained over a ready/valid port. The buffer supports stop-when-full or overwrite-oldest policy and keeps a saturating count of dropped records.

---
 rtl/ibex_rvfi_trace_buf.sv | 113 +++++++++++
 1 files changed

// File: rtl/ibex_rvfi_trace_buf.sv
// Filtered RVFI retirement capture into a circular buffer, drained over ready/valid.
// Supports drop-new or overwrite-oldest on full, plus a saturating lost-record counter.
module ibex_rvfi_trace_buf #(
    parameter int unsigned Depth        = 16,
    parameter int unsigned DropCntWidth = 16,
    parameter bit          Overwrite    = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      rvfi_valid,
    input  logic [31:0]               rvfi_pc_rdata,
    input  logic [31:0]               rvfi_insn,
    input  logic [4:0]                rvfi_rd_addr,
    input  logic [31:0]               rvfi_rd_wdata,
    input  logic                      rvfi_trap,
    input  logic                      rvfi_intr,
    input  logic [1:0]                rvfi_mode,
    input  logic [1:0]                mode_i,
    input  logic [31:0]               pc_lo_i,
    input  logic [31:0]               pc_hi_i,
    input  logic                      clear_i,
    output logic                      trace_valid_o,
    input  logic                      trace_ready_i,
    output logic [104:0]              trace_data_o,
    output logic [$clog2(Depth):0]    level_o,
    output logic [DropCntWidth-1:0]   drop_cnt_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned RecW = 105;
    localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

    logic [RecW-1:0]         mem_reg [Depth];
    logic [PtrW-1:0]         wr_ptr_reg;
    logic [PtrW-1:0]         rd_ptr_reg;
    logic [PtrW:0]           count_reg;
    logic [PtrW:0]           count_next;
    logic [DropCntWidth-1:0] drop_cnt_reg;

    logic            sel;
    logic            hit;
    logic            pop;
    logic            empty;
    logic            full;
    logic            push;
    logic            drop;
    logic            rd_adv;
    logic [RecW-1:0] rec;

    always_comb begin
        sel = 1'b0;
        case (mode_i)
            2'd0:    sel = 1'b0;
            2'd1:    sel = 1'b1;
            2'd2:    sel = rvfi_trap | rvfi_intr;
            // An inverted window (lo > hi) can never satisfy both bounds.
            default: sel = (rvfi_pc_rdata >= pc_lo_i) && (rvfi_pc_rdata <= pc_hi_i);
        endcase
    end

    assign rec   = {rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
                    rvfi_trap, rvfi_intr, rvfi_mode};
    assign hit   = rvfi_valid && sel && !clear_i;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == FullCnt);
    assign pop   = !empty && trace_ready_i && !clear_i;

    // A full-buffer hit without a pop is a loss under both policies; with
    // Overwrite the loss is the oldest entry, so the read pointer moves too.
    assign push   = hit && (!full || pop || Overwrite);
    assign drop   = hit && full && !pop;
    assign rd_adv = pop || (drop && Overwrite);

    always_comb begin
        count_next = count_reg;
        case ({push, rd_adv})
            2'b10:   count_next = count_reg + (PtrW+1)'(1);
            2'b01:   count_next = count_reg - (PtrW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
            end
            if (rd_adv) begin
                rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
            end
            count_reg <= count_next;
            if (drop && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + DropCntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= rec;
        end
    end

    assign trace_valid_o = !empty;
    assign trace_data_o  = empty ? '0 : mem_reg[rd_ptr_reg];
    assign level_o       = count_reg;
    assign drop_cnt_o    = drop_cnt_reg;

endmodule
